cs_residual_subtractor_pipe: RTL

Pipelined, parametrised successor of the packet subtractor in the intra-prediction datapath. It takes a packet of LANES unsigned samples and a prediction, then produces per-lane signed residuals without wrap-around. It also produces a per-packet sum of absolute residuals (SAD) that the mode-decision logic uses. Valid/ready handshaking on both sides lets it sit between the register bank and the CS measurement stage with back-pressure.

---
 rtl/cs_residual_subtractor_pipe_pkg.sv | 28 ++
 rtl/cs_abs_sum_tree.sv | 43 ++++
 rtl/cs_residual_subtractor_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cs_residual_subtractor_pipe_pkg.sv
// ============================================================================
// Module : cs_residual_subtractor_pipe_pkg
// Brief  : Shared defaults, mode encodings and width helper for the subtractor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cs_residual_subtractor_pipe_pkg;

    // Defaults tied to the register-bank depth of the intra-prediction path.
    localparam int CS_DATA_WIDTH = 8;
    localparam int CS_LANES      = 16;
    localparam int CS_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        CS_MODE_SPLIT   = 2'd0,
        CS_MODE_UNIFORM = 2'd1,
        CS_MODE_BYPASS  = 2'd2,
        CS_MODE_RSVD    = 2'd3
    } cs_mode_e;

    function automatic int cs_sad_width(input int data_width, input int lanes);
        return data_width + $clog2(lanes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cs_abs_sum_tree.sv
// ============================================================================
// Module : cs_abs_sum_tree
// Brief  : Combinational sum of |x| over LANES signed residuals (binary tree).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cs_abs_sum_tree #(
    parameter int LANES     = 16,
    parameter int RES_WIDTH = 9,
    parameter int SUM_WIDTH = RES_WIDTH - 1 + $clog2(LANES)
) (
    input  logic [LANES*RES_WIDTH-1:0] vec_i,
    output logic [SUM_WIDTH-1:0]       sum_o
);

    localparam int LEVELS = $clog2(LANES);

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = LANES >> l;
        logic [SUM_WIDTH-1:0] w_sum [N];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_lane
                logic [RES_WIDTH-1:0] w_x;
                logic [RES_WIDTH-1:0] w_mag;
                assign w_x      = vec_i[RES_WIDTH*i +: RES_WIDTH];
                // Magnitude never exceeds 2^(RES_WIDTH-1)-1, so no overflow here.
                assign w_mag    = w_x[RES_WIDTH-1] ? (~w_x + RES_WIDTH'(1)) : w_x;
                assign w_sum[i] = SUM_WIDTH'(w_mag);
            end
        end else begin : g_add
            for (genvar j = 0; j < N; j++) begin : g_pair
                assign w_sum[j] = g_lvl[l-1].w_sum[2*j] + g_lvl[l-1].w_sum[2*j+1];
            end
        end
    end

    assign sum_o = g_lvl[LEVELS].w_sum[0];

endmodule

`default_nettype wire

// File: rtl/cs_residual_subtractor_pipe.sv
// ============================================================================
// Module : cs_residual_subtractor_pipe
// Brief  : 2-stage valid/ready residual subtractor with per-packet SAD and
//          block packet counter. Optional clipping via CS_SUB_SATURATE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cs_residual_subtractor_pipe
    import cs_residual_subtractor_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = CS_DATA_WIDTH,
    parameter int LANES      = CS_LANES,
    parameter int RES_WIDTH  = DATA_WIDTH + 1,
    parameter int SAD_WIDTH  = DATA_WIDTH + $clog2(LANES),
    parameter int CNT_WIDTH  = CS_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0]       in_b0,
    input  logic [DATA_WIDTH-1:0]       in_b,
    input  logic [1:0]                  in_mode,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*RES_WIDTH-1:0]  out_c,
    output logic [SAD_WIDTH-1:0]        out_sad,
    output logic                        out_last,
`ifdef CS_SUB_SATURATE_EN
    output logic                        out_sat,
`endif
    output logic [CNT_WIDTH-1:0]        out_pkt_cnt
);

    logic                       s1_valid_q;
    logic [LANES*RES_WIDTH-1:0] s1_res_q;
    logic [LANES*RES_WIDTH-1:0] s1_res_d;
    logic                       s1_last_q;
    logic                       out_valid_q;
    logic [LANES*RES_WIDTH-1:0] out_c_q;
    logic [SAD_WIDTH-1:0]       out_sad_q;
    logic                       out_last_q;
    logic [CNT_WIDTH-1:0]       out_pkt_cnt_q;
    logic [CNT_WIDTH-1:0]       cnt_next_q;
    logic [SAD_WIDTH-1:0]       w_sad;
    logic                       w_s2_adv;
`ifdef CS_SUB_SATURATE_EN
    localparam logic signed [RES_WIDTH-1:0] SAT_HI = RES_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [RES_WIDTH-1:0] SAT_LO = ~SAT_HI;
    logic [LANES-1:0]           w_clip;
    logic                       s1_sat_q;
    logic                       out_sat_q;
`endif

    assign w_s2_adv = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || w_s2_adv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0]       w_a;
        logic [DATA_WIDTH-1:0]       w_pred;
        logic signed [RES_WIDTH-1:0] w_diff;

        assign w_a = in_a[DATA_WIDTH*i +: DATA_WIDTH];

        always_comb begin
            w_pred = '0;
            case (in_mode)
                CS_MODE_SPLIT:   w_pred = (i == 0) ? in_b0 : in_b;
                CS_MODE_UNIFORM: w_pred = in_b;
                default:         w_pred = '0;
            endcase
        end

        // One extra bit makes the unsigned difference exact in two's complement.
        assign w_diff = {1'b0, w_a} - {1'b0, w_pred};

`ifdef CS_SUB_SATURATE_EN
        assign w_clip[i] = (w_diff > SAT_HI) || (w_diff < SAT_LO);
        assign s1_res_d[RES_WIDTH*i +: RES_WIDTH] =
            (w_diff > SAT_HI) ? SAT_HI : ((w_diff < SAT_LO) ? SAT_LO : w_diff);
`else
        assign s1_res_d[RES_WIDTH*i +: RES_WIDTH] = w_diff;
`endif
    end

    cs_abs_sum_tree #(
        .LANES     (LANES),
        .RES_WIDTH (RES_WIDTH),
        .SUM_WIDTH (SAD_WIDTH)
    ) u_abs_sum_tree (
        .vec_i (s1_res_q),
        .sum_o (w_sad)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_res_q      <= '0;
            s1_last_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_c_q       <= '0;
            out_sad_q     <= '0;
            out_last_q    <= 1'b0;
            out_pkt_cnt_q <= '0;
            cnt_next_q    <= '0;
`ifdef CS_SUB_SATURATE_EN
            s1_sat_q      <= 1'b0;
            out_sat_q     <= 1'b0;
`endif
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_res_q  <= s1_res_d;
                    s1_last_q <= in_last;
`ifdef CS_SUB_SATURATE_EN
                    s1_sat_q  <= |w_clip;
`endif
                end
            end
            if (w_s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_c_q       <= s1_res_q;
                    out_sad_q     <= w_sad;
                    out_last_q    <= s1_last_q;
                    out_pkt_cnt_q <= cnt_next_q;
                    // The packet after a block's last one restarts at zero.
                    cnt_next_q    <= s1_last_q ? '0 : cnt_next_q + CNT_WIDTH'(1);
`ifdef CS_SUB_SATURATE_EN
                    out_sat_q     <= s1_sat_q;
`endif
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_c       = out_c_q;
    assign out_sad     = out_sad_q;
    assign out_last    = out_last_q;
    assign out_pkt_cnt = out_pkt_cnt_q;
`ifdef CS_SUB_SATURATE_EN
    assign out_sat     = out_sat_q;
`endif

endmodule

`default_nettype wire
